// File: rtl/ccm_stack_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ccm_stack_buffer
// Function : Programmable-length circular delay line for the CCM register array.
//            Optional macro STACK_VALID_OUT_EN adds a registered out_valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module ccm_stack_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 512,
  parameter int COL_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [COL_W-1:0]  col,
  input  logic [DATA_W-1:0] buf_in,
`ifdef STACK_VALID_OUT_EN
  output logic              out_valid,
`endif
  output logic [DATA_W-1:0] buf_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EXT_W = (COL_W > PTR_W) ? COL_W + 1 : PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [EXT_W-1:0]  col_ext;
  logic [PTR_W-1:0]  last_idx;
  logic [PTR_W:0]    col_eff;

  assign col_ext = EXT_W'(col);

  // Index of the final slot of the active ring: col_eff - 1, with col clamped to 1..DEPTH.
  always_comb begin
    last_idx = '0;
    if (col_ext == '0) begin
      last_idx = '0;
    end else if (col_ext > EXT_W'(DEPTH)) begin
      last_idx = PTR_W'(DEPTH - 1);
    end else begin
      last_idx = PTR_W'(col_ext - EXT_W'(1));
    end
  end

  assign col_eff = {1'b0, last_idx} + {{PTR_W{1'b0}}, 1'b1};

  // Read-before-write: the slot being overwritten holds the sample from col_eff pushes ago.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      ptr     <= '0;
      buf_out <= '0;
    end else if (en) begin
      buf_out  <= mem[ptr];
      mem[ptr] <= buf_in;
      if (ptr >= last_idx) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

`ifdef STACK_VALID_OUT_EN
  logic [PTR_W:0] fill_cnt;

  // The first real sample appears on the enabled edge after col_eff pushes have been made.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fill_cnt  <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      if (fill_cnt >= col_eff) begin
        out_valid <= 1'b1;
      end else begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_col_eff;
  assign unused_col_eff = ^col_eff;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ccm_stack_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccm_stack_buffer
// Function : Randomized and directed bench for ccm_stack_buffer against a
//            history-based delay model. Honors STACK_VALID_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccm_stack_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 512;
  localparam int COL_W  = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [COL_W-1:0]  col = '0;
  logic [DATA_W-1:0] buf_in = '0;
  logic [DATA_W-1:0] buf_out;
`ifdef STACK_VALID_OUT_EN
  logic              out_valid;
`endif

  int checks = 0;
  int errors = 0;
  int hist[$];
  int k = 0;

  ccm_stack_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .COL_W(COL_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .col      (col),
    .buf_in   (buf_in),
`ifdef STACK_VALID_OUT_EN
    .out_valid(out_valid),
`endif
    .buf_out  (buf_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int col_eff_of(input int c);
    if (c == 0) return 1;
    if (c > DEPTH) return DEPTH;
    return c;
  endfunction

  // Delay-line model: output after enabled edge k is the sample of edge k-col_eff, else 0.
  task automatic step(input logic e, input logic [DATA_W-1:0] d, input string tag);
    int ce;
    int exp;
    en = e;
    buf_in = d;
    @(posedge clk);
    #1;
    if (e) begin
      hist.push_back(int'(d));
      k++;
    end
    ce = col_eff_of(int'(col));
    exp = (k > ce) ? hist[k - ce - 1] : 0;
    check(tag, 32'(buf_out), 32'(exp));
`ifdef STACK_VALID_OUT_EN
    check({tag, "_valid"}, 32'(out_valid), (k > ce) ? 32'd1 : 32'd0);
`endif
  endtask

  // Pulse reset between clock edges and check the output clears immediately.
  task automatic pulse_reset(input int c);
    #2;
    rst_n = 1'b1;
    col = COL_W'(c);
    #1;
    check("rst_async", 32'(buf_out), 32'd0);
`ifdef STACK_VALID_OUT_EN
    check("rst_async_valid", 32'(out_valid), 32'd0);
`endif
    #1;
    rst_n = 1'b0;
    hist.delete();
    k = 0;
  endtask

  initial begin
    // Reset held with enable active must keep the output at zero.
    rst_n = 1'b1;
    en = 1'b1;
    buf_in = 8'hAA;
    col = 9'd8;
    #1;
    check("rst_imm", 32'(buf_out), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold", 32'(buf_out), 32'd0);
    end
    rst_n = 1'b0;
    hist.delete();
    k = 0;
    step(1'b0, 8'h55, "rel_idle");
    step(1'b0, 8'h66, "rel_idle");

    // Basic 8-deep delay.
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 8'(i), "basic");
      if (i == 8)  check("basic_e8", 32'(buf_out), 32'd0);
      if (i == 9)  check("basic_e9", 32'(buf_out), 32'd1);
      if (i == 10) check("basic_e10", 32'(buf_out), 32'd2);
      if (i == 40) check("basic_e40", 32'(buf_out), 32'd32);
    end

    // Enable gating.
    pulse_reset(8);
    for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), "gate_fill");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'($urandom), "gate_hold");
      check("gate_hold_c", 32'(buf_out), 32'd2);
    end
    step(1'b1, 8'd11, "gate_resume");
    check("gate_resume_c", 32'(buf_out), 32'd3);

    // Minimum lengths behave as a single register.
    pulse_reset(0);
    step(1'b1, 8'd5, "col0");
    step(1'b1, 8'd6, "col0");
    check("col0_c", 32'(buf_out), 32'd5);
    pulse_reset(1);
    step(1'b1, 8'd5, "col1");
    step(1'b1, 8'd6, "col1");
    check("col1_c", 32'(buf_out), 32'd5);

    // Maximum encodable length.
    pulse_reset(511);
    for (int i = 1; i <= 515; i++) begin
      step(1'b1, 8'(((i - 1) % 255) + 1), "col511");
      if (i == 511) check("col511_e511", 32'(buf_out), 32'd0);
      if (i == 512) check("col511_e512", 32'(buf_out), 32'd1);
    end

    // Reset mid-stream discards stored samples.
    pulse_reset(8);
    for (int i = 1; i <= 20; i++) step(1'b1, 8'(i), "mid_pre");
    pulse_reset(8);
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 8'(100 + i), "mid_post");
      if (i == 8) check("mid_post_e8", 32'(buf_out), 32'd0);
    end
    check("mid_post_e9", 32'(buf_out), 32'd101);

`ifdef STACK_VALID_OUT_EN
    pulse_reset(4);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 8'(50 + i), "valid");
      if (i == 4) check("valid_e4", 32'(out_valid), 32'd0);
      if (i == 5) begin
        check("valid_e5", 32'(out_valid), 32'd1);
        check("valid_e5_data", 32'(buf_out), 32'd51);
      end
    end
`endif

    // Randomized segments with random length, enable and data.
    for (int s = 0; s < 8; s++) begin
      int c;
      int n;
      case (s % 4)
        0: c = $urandom_range(0, 3);
        1: c = $urandom_range(4, 40);
        2: c = $urandom_range(40, 130);
        default: c = $urandom_range(0, 511);
      endcase
      pulse_reset(c);
      n = col_eff_of(c) * 2 + 40;
      if (n > 1300) n = 1300;
      for (int i = 0; i < n; i++) begin
        step(($urandom_range(0, 3) != 0), 8'($urandom), "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ccm_stack_buffer.md
Name: ccm_stack_buffer

Overview:
- Programmable-length delay line (line-buffer "stack") for the CCM register array.
- Built as a circular register array of 8-bit samples.
- Each enabled cycle pushes one sample and pops the sample pushed exactly `col` enabled cycles earlier.
- Feeds column-delayed pixel/feature data to the downstream convolution window logic.

Parameters:
- DATA_W, 8, sample width of buf_in/buf_out.
- DEPTH, 512, number of storage entries; maximum supported delay.
- COL_W, 9, width of col input.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-high (asserted when 1) despite the name; clears all state immediately.
- en  input  1  shift enable; one push/pop per rising edge while high.
- col  input  COL_W  delay length in enabled cycles (row/column length).
- buf_in  input  DATA_W  sample pushed on an enabled edge.
- buf_out  output  DATA_W  registered sample popped on the last enabled edge.

Behaviour:
- Reset (rst_n=1, async):
  - mem[0..DEPTH-1] = 0, ptr = 0, buf_out = 0.
  - Held while asserted.
  - Reset mid-operation discards all stored samples.
- Effective length col_eff:
  - col=0 -> 1.
  - col>DEPTH -> DEPTH.
  - Otherwise col.
- On rising edge with en=1, all of the following happen in the same edge:
  - buf_out <= mem[ptr] (read-before-write).
  - mem[ptr] <= buf_in.
  - ptr <= (ptr >= col_eff-1) ? 0 : ptr+1.
- en=0: mem, ptr, buf_out hold.
- Latency:
  - After the k-th enabled edge, buf_out = buf_in of enabled edge k-col_eff.
  - For k <= col_eff after reset, buf_out = 0.
- col_eff=1: buf_out equals buf_in of the previous enabled edge (1-sample register).
- Wrap-around: ptr cycles 0..col_eff-1; no full/empty flags; buffer always "full" of col_eff entries.
- col changed during operation:
  - If ptr >= new col_eff-1, ptr wraps to 0 on the next enabled edge.
  - Data integrity across a length change is not guaranteed until col_eff new samples are pushed.
- col is sampled combinationally each edge; no registering of col.
- Entries at indices >= col_eff are untouched.

Optional Feature:
- Macro STACK_VALID_OUT_EN.
- Defined:
  - Adds output out_valid (1 bit) and an internal fill counter (saturating at col_eff).
  - Counter and out_valid reset to 0.
  - On each enabled edge the counter increments until saturated.
  - out_valid is registered and goes 1 on the enabled edge where buf_out first carries a real sample, i.e. the (col_eff+1)-th enabled edge after reset; stays 1 until reset.
  - Counter and out_valid hold when en=0.
  - A change of col does not clear out_valid.
- Not defined: no out_valid port, no counter; behaviour otherwise identical.

Test Plan:
- Reset: assert rst_n=1 with en=1 and buf_in=8'hAA -> buf_out=0 immediately and while asserted; release -> buf_out stays 0 until enabled edges.
- Basic delay, col=8, en=1:
  - buf_in=1,2,3,... on successive edges -> buf_out=0 after edges 1..8.
  - buf_out=1 after edge 9, 2 after edge 10; steady 8-cycle delay through edge 40 (ptr wraps at 7).
- Enable gating, col=8:
  - Push 1..10, then drop en for 5 cycles -> buf_out holds 2.
  - Re-enable pushing 11 -> buf_out=3.
- Boundaries:
  - col=0 and col=1 -> buf_out equals previous-edge buf_in (push 5,6 -> 5 after second edge).
  - col=511 -> first nonzero output (value 1) after edge 512.
- Async reset mid-stream: col=8, after 20 pushes pulse rst_n=1 between edges -> buf_out=0 at once; next 8 enabled edges output 0, edge 9 outputs first post-reset sample.
- With STACK_VALID_OUT_EN, col=4 -> out_valid=0 after edges 1..4, 1 after edge 5 together with buf_out=first sample.
